conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Streaming 5x5 sliding-window generator that sits directly upstream of the 25-tap Conv2D multiply-accumulate stage.
- Accepts a raster-scan pixel stream (one pixel per cycle maximum) and buffers the previous four image rows in line buffers.
- Presents every fully-populated 5x5 window as a flat 25-word bus, with a valid strobe that drives the Conv2D enable.
- Valid-only convolution (no padding): output is (IMG_WIDTH-4) x (IMG_HEIGHT-4) windows per frame.

Parameters:
- DATA_WIDTH, 32, pixel/tap word width; matches the Conv2D 32-bit operand width.
- IMG_WIDTH, 28, pixels per row; must be >= 5.
- IMG_HEIGHT, 28, rows per frame; must be >= 5.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous reset, active-high.
- pix_in, in, DATA_WIDTH, incoming pixel.
- pix_valid, in, 1, pix_in is valid.
- pix_ready, out, 1, block can accept a pixel this cycle.
- out_ready, in, 1, downstream can take the current window.
- win_flat, out, 25*DATA_WIDTH, window; tap k is at bits [k*DATA_WIDTH +: DATA_WIDTH]; k = 5*row + col; k=0 is top-left (oldest row, oldest column); k=24 is the newest pixel. Maps to Conv2D input0..input24.
- win_valid, out, 1, win_flat holds a valid window; drives Conv2D enable.
- frame_done, out, 1, one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Accept event: pix_valid && pix_ready.
- pix_ready = !win_valid || out_ready. Combinational, no other dependency.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance on each accept:
  - col wraps to 0 at IMG_WIDTH-1, and row then increments.
  - row wraps to 0 at IMG_HEIGHT-1 with col wrap; frame_done pulses in that cycle +1 (registered).
- Line buffers: four single-port RAMs of depth IMG_WIDTH, chained. On accept at column c:
  - Read all four at address c (read-before-write).
  - Write pix_in into LB0 and LBi's old data into LB(i+1).
- Window shift register: 5x5 registers. On accept, each row shifts one column left, and the new column enters on the right.
  - New column, top to bottom: LB3, LB2, LB1, LB0 read data, then pix_in.
- Window validity: win_valid sets in the cycle after an accept at (row>=4, col>=4).
  - Latency 1 cycle from the accept to the window presentation.
- Output hold: while win_valid && !out_ready:
  - win_flat and win_valid are held stable.
  - pix_ready is low, so no shift occurs.
- Clearing: win_valid clears when out_ready=1 and no qualifying accept occurs in the same cycle.
  - Back-to-back qualifying accepts with out_ready high give one window per cycle.
- Row boundary: accepts at col<4 never raise win_valid (stale left columns are suppressed by the counter, not cleared).
- Frames: the next frame starts immediately after wrap. Windows are suppressed until row>=4 again, so stale previous-frame line buffer data never appears in a valid window.
- Reset values:
  - win_valid=0, frame_done=0, col=0, row=0, win_flat=0.
  - Line buffer contents are not cleared; they are don't-care because of validity gating.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is (0,0).
- Arithmetic: counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits, unsigned. Pixel data is passed through unmodified.

Optional Feature:
- Macro CONV_WIN_COORD_EN.
- Defined: adds outputs win_row [$clog2(IMG_HEIGHT-4)] and win_col [$clog2(IMG_WIDTH-4)].
  - They give the output-map coordinate of the current window (row-4, col-4 of its newest pixel).
  - They are registered alongside win_flat, reset to 0, and held under stall.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package conv_pkg holds:
  - KSIZE=5, NUM_TAPS=25, NUM_LINES=4.
  - Function tap_idx(row, col) = 5*row + col.
  - Default DATA_WIDTH=32, shared with Conv2D.
- One sub-module: conv_line_buffer.
  - Single-port, depth IMG_WIDTH, width DATA_WIDTH, synchronous read-before-write with write enable.
  - Instantiated four times.

Test Plan:
- IMG 8x8, pix = 8*r + c, pix_valid continuous, out_ready=1:
  - First win_valid the cycle after pixel 36 is accepted.
  - Taps: k0=0, k4=4, k20=32, k24=36.
  - Exactly 16 windows.
  - Last window: k0=27, k24=63.
  - frame_done pulses once.
- Row transition, same stimulus:
  - After the window with k24=39, win_valid is low for 4 accepts (pixels 40..43).
  - The next window has k24=44 and k0=8.
- Backpressure: hold out_ready=0 for 3 cycles while the window with k24=37 is presented.
  - win_flat and win_valid are stable, pix_ready=0, pixel 38 is not consumed.
  - After release, the next window has k24=38.
- Gapped input: pix_valid toggling 1/0 gives an identical window sequence to the continuous case, with no duplicate or skipped windows.
- Reset mid-frame after pixel 45:
  - win_valid=0 on the next cycle.
  - A fresh frame from pixel 100+8r+c gives a first window with k0=100 and k24=136; no stale data appears.
- Two back-to-back frames, second frame pix = 200 + 8r + c:
  - No window during frame-2 rows 0..3.
  - First frame-2 window has k0=200 and k24=236.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and helpers for the 5x5 convolution window path
//
// Purpose: kernel geometry shared by the window generator and the Conv2D stage,
//          the tap index helper and the default operand width.
// Ports:   none (package).

package conv_pkg;

  localparam int KSIZE              = 5;
  localparam int NUM_TAPS           = KSIZE * KSIZE;
  localparam int NUM_LINES          = KSIZE - 1;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Flat tap index inside the window: row 0 is the oldest row, col 0 the oldest column.
  function automatic int tap_idx(input int row, input int col);
    return KSIZE * row + col;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - single-port row buffer, synchronous read-before-write
//
// Purpose: holds one image row. On en, the word at addr is registered onto
//          rd_data and, when we is also set, wr_data replaces it in the same
//          cycle (read-before-write).
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (clears rd_data only)
//   en       in   access strobe
//   we       in   write enable, qualified by en
//   addr     in   word address, 0..DEPTH-1
//   wr_data  in   data to store
//   rd_data  out  registered old word at addr
//   old_data out  old word at addr in the current cycle, forwarded to the
//                 next buffer in the chain as its write data

module conv_line_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 28,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] old_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign old_data = mem[addr];

  // Contents are never cleared; the window generator gates validity instead.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming 5x5 sliding-window generator feeding the Conv2D MAC
//
// Purpose: buffers the previous four rows of a raster pixel stream and presents
//          every fully populated 5x5 window as a flat 25-word bus (valid-only
//          convolution, no padding). Optional macro CONV_WIN_COORD_EN adds the
//          output-map coordinate of each window (win_row, win_col).
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   pix_in      in   incoming pixel
//   pix_valid   in   pix_in is valid
//   pix_ready   out  block can accept a pixel this cycle
//   out_ready   in   downstream can take the current window
//   win_flat    out  window, tap k = 5*row + col at [k*DATA_WIDTH +: DATA_WIDTH]
//   win_valid   out  win_flat holds a valid window (Conv2D enable)
//   frame_done  out  one-cycle pulse after the last pixel of a frame is accepted
//   win_row     out  (CONV_WIN_COORD_EN) output-map row of the current window
//   win_col     out  (CONV_WIN_COORD_EN) output-map column of the current window

module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  localparam int WIN_ROW_W  = ($clog2(IMG_HEIGHT - KSIZE + 1) > 0) ? $clog2(IMG_HEIGHT - KSIZE + 1) : 1,
  localparam int WIN_COL_W  = ($clog2(IMG_WIDTH - KSIZE + 1) > 0) ? $clog2(IMG_WIDTH - KSIZE + 1) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          pix_in,
  input  logic                           pix_valid,
  output logic                           pix_ready,
  input  logic                           out_ready,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] win_flat,
  output logic                           win_valid,
  output logic                           frame_done
`ifdef CONV_WIN_COORD_EN
  ,
  output logic [WIN_ROW_W-1:0]           win_row,
  output logic [WIN_COL_W-1:0]           win_col
`endif
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             win_hit;

  // Line buffer 0 holds the row just above the current one, buffer 3 the oldest.
  logic [DATA_WIDTH-1:0] lb_wr  [NUM_LINES];
  logic [DATA_WIDTH-1:0] lb_rd  [NUM_LINES];
  logic [DATA_WIDTH-1:0] lb_old [NUM_LINES];
  logic                  unused_tail;

  // Columns 0..3 of the window are plain shift registers; column 4 is formed
  // by the line buffer read registers plus pix_q, all loaded on the same accept.
  logic [DATA_WIDTH-1:0] shift_q  [KSIZE][KSIZE-1];
  logic [DATA_WIDTH-1:0] pix_q;
  logic [DATA_WIDTH-1:0] edge_col [KSIZE];

  assign pix_ready = !win_valid || out_ready;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col_q == COL_W'(IMG_WIDTH - 1));
  assign row_last  = (row_q == ROW_W'(IMG_HEIGHT - 1));
  // Only an accept with four full rows above and four columns to the left
  // completes a window; this also hides stale columns and previous-frame rows.
  assign win_hit   = accept && (row_q >= ROW_W'(KSIZE - 1)) && (col_q >= COL_W'(KSIZE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && col_last && row_last;
      if (accept) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
    end else if (win_hit) begin
      win_valid <= 1'b1;
    end else if (out_ready) begin
      win_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_wr[i] = pix_in;
    end else begin : g_chain
      assign lb_wr[i] = lb_old[i-1];
    end

    conv_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH),
      .ADDR_WIDTH (COL_W)
    ) u_lb (
      .clk      (clk),
      .rst      (rst),
      .en       (accept),
      .we       (accept),
      .addr     (col_q),
      .wr_data  (lb_wr[i]),
      .rd_data  (lb_rd[i]),
      .old_data (lb_old[i])
    );
  end

  // The oldest row falls off the end of the chain.
  assign unused_tail = ^lb_old[NUM_LINES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= '0;
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) begin
          shift_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      pix_q <= pix_in;
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 2; c++) begin
          shift_q[r][c] <= shift_q[r][c+1];
        end
        shift_q[r][KSIZE-2] <= edge_col[r];
      end
    end
  end

  for (genvar r = 0; r < KSIZE; r++) begin : g_edge
    if (r < NUM_LINES) begin : g_from_lb
      assign edge_col[r] = lb_rd[NUM_LINES-1-r];
    end else begin : g_from_pix
      assign edge_col[r] = pix_q;
    end
  end

  for (genvar r = 0; r < KSIZE; r++) begin : g_row
    for (genvar c = 0; c < KSIZE; c++) begin : g_col
      if (c < KSIZE - 1) begin : g_shift
        assign win_flat[tap_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = shift_q[r][c];
      end else begin : g_newest
        assign win_flat[tap_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = edge_col[r];
      end
    end
  end

`ifdef CONV_WIN_COORD_EN
  logic [ROW_W-1:0] row_off;
  logic [COL_W-1:0] col_off;

  assign row_off = row_q - ROW_W'(KSIZE - 1);
  assign col_off = col_q - COL_W'(KSIZE - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      win_row <= '0;
      win_col <= '0;
    end else if (win_hit) begin
      win_row <= row_off[WIN_ROW_W-1:0];
      win_col <= col_off[WIN_COL_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - directed self-checking bench for conv_window_gen on an 8x8 image

module tb_conv_window_gen;

  localparam int DW = 32;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int FW = 25 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          pix_ready;
  logic          out_ready = 1'b1;
  logic [FW-1:0] win_flat;
  logic          win_valid;
  logic          frame_done;
`ifdef CONV_WIN_COORD_EN
  logic [1:0]    win_row;
  logic [1:0]    win_col;
`endif

  int checks = 0;
  int errors = 0;
  int win_cnt = 0;
  int fd_cnt = 0;
  logic [DW-1:0] k0_q[$];
  logic [DW-1:0] k24_q[$];
  logic [DW-1:0] ref_k24[$];
  logic [FW-1:0] snap;

  conv_window_gen #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .out_ready  (out_ready),
    .win_flat   (win_flat),
    .win_valid  (win_valid),
    .frame_done (frame_done)
`ifdef CONV_WIN_COORD_EN
    ,
    .win_row    (win_row),
    .win_col    (win_col)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] tap(input logic [FW-1:0] f, input int k);
    return f[k*DW +: DW];
  endfunction

  // Records each window as it is handed to the consumer, plus frame_done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (win_valid && out_ready) begin
        win_cnt++;
        k0_q.push_back(tap(win_flat, 0));
        k24_q.push_back(tap(win_flat, 24));
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    win_cnt = 0;
    fd_cnt = 0;
    k0_q.delete();
    k24_q.delete();
  endtask

  // Offers one pixel and returns 1 ns after the edge that accepted it.
  task automatic send(input logic [DW-1:0] p);
    bit ok;
    ok = 1'b0;
    pix_in = p;
    pix_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pix_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      check("send_timeout", 32'(ok), 32'd1);
    end
    pix_valid = 1'b0;
  endtask

  task automatic check_win(input string tag, input int base, input int r, input int c);
    for (int k = 0; k < 25; k++) begin
      check($sformatf("%s_k%0d", tag, k), tap(win_flat, k),
            DW'(base + W * (r - 4 + k / 5) + (c - 4 + k % 5)));
    end
  endtask

  task automatic run_frame(input int base, input bit gapped);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(DW'(base + W * r + c));
        check($sformatf("valid_b%0d_r%0dc%0d", base, r, c), 32'(win_valid), 32'((r >= 4) && (c >= 4)));
        check($sformatf("fdone_b%0d_r%0dc%0d", base, r, c), 32'(frame_done), 32'((r == H - 1) && (c == W - 1)));
        if (r >= 4 && c >= 4) check_win($sformatf("win_b%0d_r%0dc%0d", base, r, c), base, r, c);
        if (gapped) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_win_valid", 32'(win_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_pix_ready", 32'(pix_ready), 32'd1);
    for (int k = 0; k < 25; k++) check($sformatf("rst_flat_k%0d", k), tap(win_flat, k), 32'd0);

    // Continuous frame.
    do_reset();
    run_frame(0, 1'b0);
    drain();
    check("a_valid_cleared", 32'(win_valid), 32'd0);
    check("a_win_cnt", win_cnt, 32'd16);
    check("a_fd_cnt", fd_cnt, 32'd1);
    check("a_first_k0", k0_q[0], 32'd0);
    check("a_first_k24", k24_q[0], 32'd36);
    check("a_rowend_k24", k24_q[3], 32'd39);
    check("a_rownext_k24", k24_q[4], 32'd44);
    check("a_rownext_k0", k0_q[4], 32'd8);
    check("a_last_k0", k0_q[15], 32'd27);
    check("a_last_k24", k24_q[15], 32'd63);
    ref_k24 = k24_q;

    // Gapped input gives the same window sequence.
    do_reset();
    run_frame(0, 1'b1);
    drain();
    check("g_win_cnt", win_cnt, 32'd16);
    check("g_fd_cnt", fd_cnt, 32'd1);
    for (int i = 0; i < 16; i++) check($sformatf("g_seq%0d", i), k24_q[i], ref_k24[i]);

    // Backpressure on the window whose newest pixel is 37.
    do_reset();
    for (int p = 0; p <= 37; p++) send(DW'(p));
    check("bp_pre_valid", 32'(win_valid), 32'd1);
    check("bp_pre_k24", tap(win_flat, 24), 32'd37);
    out_ready = 1'b0;
    pix_in = 32'd38;
    pix_valid = 1'b1;
    snap = win_flat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_ready_%0d", i), 32'(pix_ready), 32'd0);
      check($sformatf("bp_valid_%0d", i), 32'(win_valid), 32'd1);
      for (int k = 0; k < 25; k++) check($sformatf("bp_hold_%0d_k%0d", i, k), tap(win_flat, k), tap(snap, k));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'd38);
    check("bp_post_valid", 32'(win_valid), 32'd1);
    check_win("bp_post", 0, 4, 6);
    drain();
    check("bp_win_cnt", win_cnt, 32'd3);
    check("bp_seq0", k24_q[0], 32'd36);
    check("bp_seq1", k24_q[1], 32'd37);
    check("bp_seq2", k24_q[2], 32'd38);

    // Reset in the middle of a frame.
    do_reset();
    for (int p = 0; p <= 45; p++) send(DW'(p));
    check("mr_pre_valid", 32'(win_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_valid_low", 32'(win_valid), 32'd0);
    check("mr_flat_k24", tap(win_flat, 24), 32'd0);
    rst = 1'b0;
    win_cnt = 0;
    fd_cnt = 0;
    k0_q.delete();
    k24_q.delete();
    run_frame(100, 1'b0);
    drain();
    check("mr_win_cnt", win_cnt, 32'd16);
    check("mr_first_k0", k0_q[0], 32'd100);
    check("mr_first_k24", k24_q[0], 32'd136);

    // Two frames back to back.
    do_reset();
    run_frame(0, 1'b0);
    run_frame(200, 1'b0);
    drain();
    check("bb_win_cnt", win_cnt, 32'd32);
    check("bb_fd_cnt", fd_cnt, 32'd2);
    check("bb_f2_first_k0", k0_q[16], 32'd200);
    check("bb_f2_first_k24", k24_q[16], 32'd236);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
